// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// Pipeline stage register for the processor datapath. It carries CHANNELS
// independent WIDTH-bit fields per beat and supports a valid/ready handshake,
// freeze (stall) and flush (bubble insert).
//
// With SKID=1 a one-entry skid buffer sits behind the main register. in_ready
// then depends only on registered state, freeze and rst, so there is no
// combinational path from out_ready to in_ready. With SKID=0 there is a single
// register, and ready passes through combinationally.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   freeze     stage hold; no state change while high
//   flush      synchronous clear of all held beats (priority over freeze)
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat this cycle
//   in_data    upstream beat; channel k at bits [k*WIDTH +: WIDTH]
//   out_valid  beat presented downstream
//   out_ready  downstream accepts the beat
//   out_data   presented beat (always the main register)
//   occupancy  number of held beats (0..2; max 1 when SKID=0)
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int SKID     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      freeze,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [1:0]                occupancy
);

  localparam int DW = CHANNELS * WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_SKIDDED = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [DW-1:0]   main_r;
  logic [DW-1:0]   main_nx_s;
  logic [DW-1:0]   skid_r;
  logic [DW-1:0]   skid_nx_s;
  logic            out_valid_r;
  logic [1:0]      occ_r;
  logic            ready_s;
  logic            accept_s;
  logic            pop_s;

  // Number of beats held in a given state.
  function automatic logic [1:0] occ_of(input state_t s);
    logic [1:0] n;
    case (s)
      ST_EMPTY:   n = 2'd0;
      ST_FULL:    n = 2'd1;
      ST_SKIDDED: n = 2'd2;
      default:    n = 2'd0;
    endcase
    return n;
  endfunction

  // Upstream ready: registered-state based with a skid entry, pass-through otherwise.
  always_comb begin
    ready_s = 1'b0;
    if (SKID != 0) begin
      ready_s = (state_r != ST_SKIDDED) && !freeze && rst;
    end else begin
      ready_s = (!out_valid_r || out_ready) && !freeze && rst;
    end
  end

  assign accept_s = in_valid && ready_s;
  assign pop_s    = out_valid_r && out_ready && !freeze;

  // Next-state and next-data selection; flush wins over freeze, accept and pop.
  always_comb begin
    state_nx_s = state_r;
    main_nx_s  = main_r;
    skid_nx_s  = skid_r;
    if (flush) begin
      state_nx_s = ST_EMPTY;
    end else if (freeze) begin
      state_nx_s = state_r;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nx_s = ST_FULL;
            main_nx_s  = in_data;
          end else begin
            state_nx_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (accept_s && pop_s) begin
            state_nx_s = ST_FULL;
            main_nx_s  = in_data;
          end else if (accept_s) begin
            // Without a skid entry an accept in FULL always coincides with a
            // pop, so this branch only matters for SKID=1.
            if (SKID != 0) begin
              state_nx_s = ST_SKIDDED;
              skid_nx_s  = in_data;
            end else begin
              state_nx_s = ST_FULL;
              main_nx_s  = in_data;
            end
          end else if (pop_s) begin
            state_nx_s = ST_EMPTY;
          end else begin
            state_nx_s = ST_FULL;
          end
        end
        ST_SKIDDED: begin
          if (pop_s) begin
            state_nx_s = ST_FULL;
            main_nx_s  = skid_r;
          end else begin
            state_nx_s = ST_SKIDDED;
          end
        end
        default: begin
          state_nx_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State, data and registered output flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_EMPTY;
      main_r      <= '0;
      skid_r      <= '0;
      out_valid_r <= 1'b0;
      occ_r       <= 2'd0;
    end else begin
      state_r     <= state_nx_s;
      main_r      <= main_nx_s;
      skid_r      <= skid_nx_s;
      out_valid_r <= (state_nx_s != ST_EMPTY);
      occ_r       <= occ_of(state_nx_s);
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = occ_r;

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised pipeline stage register for the processor datapath (IF/ID/EXE/MEM/WB boundaries).
- Carries CHANNELS independent WIDTH-bit fields per beat, with a valid/ready handshake, freeze (stall) and flush (bubble insert).
- With SKID=1, a one-entry skid buffer keeps in_ready free of any combinational path from out_ready, so stage-to-stage ready timing is cut.

Parameters:
WIDTH, 32, bits per channel
CHANNELS, 2, number of parallel channels carried per beat
SKID, 1, 1 = main register plus skid entry (registered ready); 0 = single register (ready passes through combinationally)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (rst=0 resets)
freeze  input  1  stage hold; no state change while high
flush  input  1  synchronous clear of all held beats
in_valid  input  1  upstream beat present
in_ready  output  1  stage can accept a beat this cycle
in_data  input  CHANNELS*WIDTH  upstream beat; channel k at bits [k*WIDTH +: WIDTH]
out_valid  output  1  beat presented downstream
out_ready  input  1  downstream accepts the beat
out_data  output  CHANNELS*WIDTH  presented beat, same channel packing as in_data
occupancy  output  2  number of held beats (0..2; max 1 when SKID=0)

Behaviour:
- Reset (rst=0, async):
  - state EMPTY; main and skid data = 0; out_valid=0; out_data=0; occupancy=0.
  - in_ready=0 while rst=0.
- Event definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready & !freeze.
- Latency: an accepted beat appears on out_data/out_valid the next cycle. Order is preserved and beats are never duplicated or dropped, except by flush.
- out_data always reflects the main register. Skid contents are never visible on the output directly.
- SKID=1 states:
  - EMPTY: out_valid=0, occupancy=0.
  - FULL: main valid, occupancy=1.
  - SKIDDED: main and skid valid, occupancy=2.
- SKID=1 ready: in_ready = (state != SKIDDED) & !freeze & rst. It depends on registered state, freeze and rst only, never on out_ready.
- SKID=1 transitions (when !flush and !freeze):
  - EMPTY: accept -> FULL, main<=in_data.
  - FULL: accept & pop -> FULL, main<=in_data.
  - FULL: accept & !pop -> SKIDDED, skid<=in_data.
  - FULL: !accept & pop -> EMPTY.
  - SKIDDED: pop -> FULL, main<=skid (no accept possible).
  - SKIDDED: !pop -> hold.
- SKID=0 states: EMPTY or FULL only.
  - in_ready = (!out_valid | out_ready) & !freeze & rst (combinational).
  - accept -> FULL, main<=in_data.
  - pop & !accept -> EMPTY.
- freeze=1:
  - All registers hold; in_ready=0; pop cannot occur.
  - out_valid and out_data stay stable.
- flush=1:
  - Next state EMPTY, occupancy 0, out_valid 0.
  - Flush has priority over freeze, accept and pop. A beat offered in the flush cycle is dropped.
  - Data registers may keep stale contents; out_data is don't-care while out_valid=0.
  - in_ready follows its normal equation during flush (an upstream handshake may complete but is discarded).
- Simultaneous accept and pop in FULL: throughput of 1 beat/cycle, occupancy unchanged.
- Reset mid-operation: all held beats lost immediately (async). First accept is possible in the first cycle after rst returns to 1.
- Width: pure transport, no arithmetic. Channels are never reordered or shifted.

Test Plan:
- Reset release, SKID=1, WIDTH=32, CHANNELS=2: rst 0->1 -> out_valid=0, occupancy=0, in_ready=1; in_data=0x0000_0002_0000_0001 accepted -> next cycle out_data=0x0000_0002_0000_0001, out_valid=1.
- Streaming with out_ready=1: beats 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on consecutive cycles, occupancy stays 1, in_ready never drops.
- Backpressure: out_ready=0 while beats A,B are sent -> occupancy 2, in_ready=0, out_data=A. Raise out_ready -> A then B emerge, occupancy 2->1->0.
- Freeze: with out_valid=1 and out_data=C, hold freeze=1 for 3 cycles with in_valid=1 and out_ready=1 -> out_data=C constant, in_ready=0, no pop. After release, C pops first.
- Flush with freeze=1 and occupancy=2 -> next cycle out_valid=0, occupancy=0. A beat offered in the flush cycle never appears on the output.
- SKID=0 build: out_ready=0 -> in_ready=0 in the same cycle while FULL; out_ready=1 with in_valid=1 -> accept and pop in the same cycle, occupancy never exceeds 1.
